onehot_encoder_seq: RTL and testbench
=====================================

Name: onehot_encoder_seq

Overview:
- Reverse direction of the team's 3-to-8 one-hot decoder: accepts an 8-bit line vector and emits the 3-bit binary code of every set line, one code per output beat.
- Bit k of the input maps to code k, the exact inverse of the decoder mapping: 3'b000 maps to 8'b0000_0001, through 3'b111 to 8'b1000_0000.
- Sits between request/flag sources and any consumer of 3-bit indices. Uses valid/ready handshakes on both sides.

Parameters:
- MSB_FIRST, 0, emission order: 0 = lowest set bit first, 1 = highest set bit first.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- in_vld  input  1  in_data valid.
- in_data  input  8  line vector to encode.
- in_rdy  output  1  block can accept a vector.
- out_vld  output  1  out_code valid.
- out_code  output  3  binary index of the current set line.
- out_last  output  1  current beat is the final beat for the vector.
- out_zero  output  1  accepted vector was all-zero (single dummy beat).
- out_rdy  input  1  consumer accepts the current beat.

Behaviour:
- Clocking and reset:
  - One clock: sys_clk.
  - Reset is synchronous and active-high on sys_rst.
  - Reset dominates every other input in the same cycle.
- Reset values:
  - state = IDLE, rem = 8'h00.
  - out_vld = 0, out_code = 3'd0, out_last = 0, out_zero = 0.
  - in_rdy = 1 from the first cycle after reset (in_rdy is 1 exactly when state == IDLE).
- States: IDLE, EMIT.
- IDLE:
  - in_vld & in_rdy loads rem <= in_data and moves to EMIT.
  - Next cycle: out_vld = 1 and out_code = first set bit per MSB_FIRST.
  - out_last = 1 if popcount(in_data) == 1.
  - Acceptance-to-first-beat latency is 1 cycle.
- Zero vector:
  - in_data == 8'h00 produces exactly one beat: out_code = 0, out_zero = 1, out_last = 1.
  - out_zero is 0 on every beat of a nonzero vector.
- EMIT, beat transfer:
  - A beat transfers when out_vld & out_rdy.
  - On transfer with out_last = 0: clear the emitted bit in rem, present the next set bit's code next cycle, recompute out_last (1 when exactly one bit remains).
  - Sustained throughput is 1 beat/cycle while out_rdy is held high.
- EMIT, last beat:
  - On transfer with out_last = 1: out_vld <= 0, out_last <= 0, out_zero <= 0, return to IDLE.
  - in_rdy rises the cycle after the last transfer, giving 1 bubble cycle between vectors.
- Backpressure:
  - While out_vld & !out_rdy, out_code, out_last, out_zero and rem hold stable.
  - No beat is dropped or duplicated.
- in_rdy = 0 throughout EMIT. in_vld/in_data are ignored there, and the source must hold them.
- Beat count per vector = max(1, popcount(in_data)), range 1..8. For in_data = 8'hFF, exactly 8 beats, codes 0..7 (MSB_FIRST = 0).
- Next-bit selection is a priority search over rem (LSB- or MSB-priority per MSB_FIRST), registered into out_code.
- Reset mid-burst: remaining bits are discarded, outputs return to reset values next cycle, and no partial beat is produced.
- No latches: every combinational path has a default assignment.

Test Plan:
- Reset, in_vld = 0 -> in_rdy = 1, out_vld = 0, out_code = 0, out_last = 0, out_zero = 0.
- in_data = 8'h20, out_rdy = 1 -> one beat 1 cycle after acceptance: out_code = 5, out_last = 1. in_rdy = 1 two cycles after acceptance.
- in_data = 8'hA5, out_rdy = 1, MSB_FIRST = 0 -> back-to-back codes 0, 2, 5, 7, out_last only on 7. Same vector with MSB_FIRST = 1 -> 7, 5, 2, 0, out_last only on 0.
- in_data = 8'hA5, out_rdy low for 3 cycles on beat 2 -> out_code holds 2 for all stalled cycles, then 5, 7. Exactly 4 transfers.
- in_data = 8'h00 -> single beat: out_code = 0, out_zero = 1, out_last = 1. Then in_data = 8'hFF -> 8 beats, codes 0..7, out_zero = 0.
- Exhaustive round-trip: each code 0..7 through the 3-to-8 decoder into this block -> single beat returning the original code, out_last = 1. Additionally, sys_rst pulsed after 2nd beat of 8'hFF -> out_vld = 0 next cycle, in_rdy = 1, no further beats.

Source files
------------

// File: rtl/onehot_encoder_seq.sv
// Sequential one-hot/multi-hot encoder: accepts an 8-bit line vector and emits
// the 3-bit index of every set line, one code per valid/ready beat.
module onehot_encoder_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  output logic       out_vld,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_zero,
  input  logic       out_rdy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] rem_after;
  logic       vld_d, last_d, zero_d;
  logic [2:0] code_d;

  // Priority search: the last assignment in loop order wins, so the loop
  // direction is opposite to the desired priority.
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // True for zero or exactly one set bit; a zero vector is also a one-beat burst.
  function automatic logic at_most_one(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

  assign in_rdy = (state_q == IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    vld_d     = out_vld;
    code_d    = out_code;
    last_d    = out_last;
    zero_d    = out_zero;
    rem_after = rem_q & ~(8'd1 << out_code);

    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          state_d = EMIT;
          rem_d   = in_data;
          vld_d   = 1'b1;
          code_d  = first_set(in_data);
          last_d  = at_most_one(in_data);
          zero_d  = (in_data == 8'd0);
        end
      end
      EMIT: begin
        if (out_rdy) begin
          if (out_last) begin
            state_d = IDLE;
            rem_d   = 8'd0;
            vld_d   = 1'b0;
            code_d  = 3'd0;
            last_d  = 1'b0;
            zero_d  = 1'b0;
          end else begin
            rem_d  = rem_after;
            code_d = first_set(rem_after);
            last_d = at_most_one(rem_after);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      rem_q    <= 8'd0;
      out_vld  <= 1'b0;
      out_code <= 3'd0;
      out_last <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      out_vld  <= vld_d;
      out_code <= code_d;
      out_last <= last_d;
      out_zero <= zero_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Directed bench for onehot_encoder_seq: LSB-first and MSB-first instances
// share all inputs and are checked against hand-computed code sequences.
module tb_onehot_encoder_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in_vld;
  logic [7:0] in_data;
  logic       out_rdy;

  logic       in_rdy_l, out_vld_l, out_last_l, out_zero_l;
  logic [2:0] out_code_l;
  logic       in_rdy_m, out_vld_m, out_last_m, out_zero_m;
  logic [2:0] out_code_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  onehot_encoder_seq #(.MSB_FIRST(1'b0)) dut_lsb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_rdy  (in_rdy_l),
    .out_vld (out_vld_l),
    .out_code(out_code_l),
    .out_last(out_last_l),
    .out_zero(out_zero_l),
    .out_rdy (out_rdy)
  );

  onehot_encoder_seq #(.MSB_FIRST(1'b1)) dut_msb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_rdy  (in_rdy_m),
    .out_vld (out_vld_m),
    .out_code(out_code_m),
    .out_last(out_last_m),
    .out_zero(out_zero_m),
    .out_rdy (out_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_rdy_l"},  32'(in_rdy_l),   32'd1);
    check({tag, " in_rdy_m"},  32'(in_rdy_m),   32'd1);
    check({tag, " out_vld_l"}, 32'(out_vld_l),  32'd0);
    check({tag, " out_vld_m"}, 32'(out_vld_m),  32'd0);
    check({tag, " out_last"},  32'(out_last_l), 32'd0);
    check({tag, " out_zero"},  32'(out_zero_l), 32'd0);
  endtask

  // Beat i of the expected LSB-first/MSB-first sequences sits at bits [3*i +: 3].
  task automatic run_vector(input string tag, input logic [7:0] data, input int n_beats,
                            input logic [23:0] exp_l, input logic [23:0] exp_m,
                            input bit zero, input int stall_beat, input int stall_n);
    check({tag, " accept in_rdy"}, 32'(in_rdy_l), 32'd1);
    in_vld  = 1'b1;
    in_data = data;
    step();
    in_vld  = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      if (b == stall_beat) begin
        out_rdy = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check($sformatf("%s stall%0d vld", tag, s),  32'(out_vld_l),  32'd1);
          check($sformatf("%s stall%0d code", tag, s), 32'(out_code_l), 32'(exp_l[3*b +: 3]));
          check($sformatf("%s stall%0d last", tag, s), 32'(out_last_l), 32'(b == n_beats - 1));
          step();
        end
      end
      out_rdy = 1'b1;
      check($sformatf("%s b%0d vld_l", tag, b),  32'(out_vld_l),  32'd1);
      check($sformatf("%s b%0d vld_m", tag, b),  32'(out_vld_m),  32'd1);
      check($sformatf("%s b%0d code_l", tag, b), 32'(out_code_l), 32'(exp_l[3*b +: 3]));
      check($sformatf("%s b%0d code_m", tag, b), 32'(out_code_m), 32'(exp_m[3*b +: 3]));
      check($sformatf("%s b%0d last_l", tag, b), 32'(out_last_l), 32'(b == n_beats - 1));
      check($sformatf("%s b%0d last_m", tag, b), 32'(out_last_m), 32'(b == n_beats - 1));
      check($sformatf("%s b%0d zero_l", tag, b), 32'(out_zero_l), 32'(zero));
      check($sformatf("%s b%0d zero_m", tag, b), 32'(out_zero_m), 32'(zero));
      check($sformatf("%s b%0d in_rdy", tag, b), 32'(in_rdy_l),   32'd0);
      step();
    end
    check_idle({tag, " done"});
  endtask

  initial begin
    logic [7:0] onehot;
    sys_rst = 1'b1;
    in_vld  = 1'b0;
    in_data = 8'h00;
    out_rdy = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    check_idle("reset");
    check("reset code_l", 32'(out_code_l), 32'd0);
    check("reset code_m", 32'(out_code_m), 32'd0);

    run_vector("single20", 8'h20, 1, {21'd0, 3'd5}, {21'd0, 3'd5}, 1'b0, -1, 0);
    run_vector("a5", 8'hA5, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0},
               {12'd0, 3'd0, 3'd2, 3'd5, 3'd7}, 1'b0, -1, 0);
    run_vector("a5stall", 8'hA5, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0},
               {12'd0, 3'd0, 3'd2, 3'd5, 3'd7}, 1'b0, 1, 3);
    run_vector("zero", 8'h00, 1, 24'd0, 24'd0, 1'b1, -1, 0);
    run_vector("ff", 8'hFF, 8,
               {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
               {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 1'b0, -1, 0);

    // Round trip through a 3-to-8 decoder.
    for (int k = 0; k < 8; k++) begin
      onehot = 8'd1 << k;
      run_vector($sformatf("rt%0d", k), onehot, 1, 24'(k), 24'(k), 1'b0, -1, 0);
    end

    // Reset after the second beat of 8'hFF discards the rest of the burst.
    in_vld  = 1'b1;
    in_data = 8'hFF;
    step();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    check("rst_mid b0 code", 32'(out_code_l), 32'd0);
    step();
    check("rst_mid b1 code", 32'(out_code_l), 32'd1);
    check("rst_mid b1 code_m", 32'(out_code_m), 32'd6);
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check_idle("rst_mid");
    check("rst_mid code", 32'(out_code_l), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_mid quiet%0d", c), 32'(out_vld_l | out_vld_m), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
